// File: rtl/pipe_ctrl.sv
// Generic valid/allow_in pipeline controller with per-stage flush and retire tracking.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int unsigned STAGES = 5,
  parameter int unsigned W      = 64,
  parameter int unsigned SW     = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  output logic                     in_ready,
  input  logic [STAGES-1:0]        stage_over,
  input  logic                     flush_req,
  input  logic [SW-1:0]            flush_stage,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES-1:0]        stage_allow_in,
  output logic [STAGES*W-1:0]      stage_data,
  output logic                     retire,
  output logic [W-1:0]             retire_data,
  output logic [(STAGES+1)*32-1:0] perf_cnt
);

  localparam int unsigned Last = STAGES - 1;

  logic [STAGES-1:0]   valid_q, valid_d;
  logic [STAGES-1:0]   allow_in;
  logic [STAGES-1:0]   kill;
  logic [STAGES-1:0]   adv;
  logic [STAGES*W-1:0] data_q;

  // A stage may accept when empty, or when its own entry leaves this cycle.
  always_comb begin
    allow_in       = '0;
    allow_in[Last] = ~valid_q[Last] | stage_over[Last];
    for (int i = int'(Last) - 1; i >= 0; i--) begin
      allow_in[i] = ~valid_q[i] | (stage_over[i] & allow_in[i+1]);
    end
  end

  always_comb begin
    kill = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      kill[i] = flush_req & (i <= int'(flush_stage));
    end
  end

  assign in_ready = allow_in[0] & ~flush_req;

  always_comb begin
    adv     = '0;
    valid_d = '0;
    adv[0]  = in_valid & in_ready;
    for (int i = 1; i < int'(STAGES); i++) begin
      adv[i] = valid_q[i-1] & stage_over[i-1] & allow_in[i] & ~kill[i-1];
    end
    for (int i = 0; i < int'(STAGES); i++) begin
      valid_d[i] = ~kill[i] & (adv[i] | (valid_q[i] & ~allow_in[i]));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload is deliberately left unreset; it is only meaningful under valid.
  always_ff @(posedge clk) begin
    if (adv[0]) begin
      data_q[W-1:0] <= in_data;
    end
    for (int i = 1; i < int'(STAGES); i++) begin
      if (adv[i]) begin
        data_q[i*W +: W] <= data_q[(i-1)*W +: W];
      end
    end
  end

  assign stage_valid    = valid_q;
  assign stage_allow_in = allow_in;
  assign stage_data     = data_q;
  assign retire         = valid_q[Last] & stage_over[Last] & ~kill[Last];
  assign retire_data    = data_q[Last*W +: W];

`ifdef PIPE_CTRL_PERF_EN
  logic [STAGES:0][31:0] cnt_q;
  logic [STAGES-1:0]     stall;

  always_comb begin
    stall = '0;
    for (int i = 0; i < int'(Last); i++) begin
      stall[i] = valid_q[i] & ~(stage_over[i] & allow_in[i+1]);
    end
    stall[Last] = valid_q[Last] & ~stage_over[Last];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(STAGES); i++) begin
        if (stall[i]) begin
          cnt_q[i] <= cnt_q[i] + 32'd1;
        end
      end
      if (flush_req) begin
        cnt_q[STAGES] <= cnt_q[STAGES] + 32'd1;
      end
    end
  end

  assign perf_cnt = cnt_q;
`else
  assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: an entry-level pipeline model checked every cycle,
// plus literal expectations for latency, stall, flush, reset and perf scenarios.
module tb_pipe_ctrl;

  localparam int STAGES = 5;
  localparam int W      = 16;
  localparam int SW     = 3;

  logic                     clk;
  logic                     reset;
  logic                     in_valid;
  logic [W-1:0]             in_data;
  logic                     in_ready;
  logic [STAGES-1:0]        stage_over;
  logic                     flush_req;
  logic [SW-1:0]            flush_stage;
  logic [STAGES-1:0]        stage_valid;
  logic [STAGES-1:0]        stage_allow_in;
  logic [STAGES*W-1:0]      stage_data;
  logic                     retire;
  logic [W-1:0]             retire_data;
  logic [(STAGES+1)*32-1:0] perf_cnt;

  pipe_ctrl #(
    .STAGES(STAGES),
    .W     (W),
    .SW    (SW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .stage_over    (stage_over),
    .flush_req     (flush_req),
    .flush_stage   (flush_stage),
    .stage_valid   (stage_valid),
    .stage_allow_in(stage_allow_in),
    .stage_data    (stage_data),
    .retire        (retire),
    .retire_data   (retire_data),
    .perf_cnt      (perf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: each slot holds a payload or -1 when empty.
  int          ent   [STAGES];
  int unsigned m_cnt [STAGES+1];
  bit          m_acc;

  // An entry leaves its slot when done and the slot ahead is empty or also emptying.
  task automatic model_eval(output logic [STAGES-1:0] lv, output logic [STAGES-1:0] kl,
                            output logic rdy);
    lv = '0;
    kl = '0;
    for (int s = 0; s < STAGES; s++) kl[s] = flush_req && (s <= int'(flush_stage));
    for (int s = STAGES - 1; s >= 0; s--) begin
      bit ahead_free;
      ahead_free = (s == STAGES - 1) ? 1'b1 : ((ent[s+1] < 0) || lv[s+1]);
      lv[s] = (ent[s] >= 0) && stage_over[s] && ahead_free;
    end
    rdy = ((ent[0] < 0) || lv[0]) && !flush_req;
  endtask

  initial begin
    for (int s = 0; s < STAGES; s++) ent[s] = -1;
    for (int s = 0; s <= STAGES; s++) m_cnt[s] = 0;
    m_acc = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int s = 0; s < STAGES; s++) ent[s] = -1;
        for (int s = 0; s <= STAGES; s++) m_cnt[s] = 0;
        m_acc = 0;
      end else begin
        logic [STAGES-1:0] lv, kl;
        logic              rdy;
        int                nxt [STAGES];
        model_eval(lv, kl, rdy);
        for (int s = 0; s < STAGES; s++) begin
          if (kl[s]) nxt[s] = -1;
          else if (s > 0 && lv[s-1] && !kl[s-1]) nxt[s] = ent[s-1];
          else if (s == 0 && in_valid && rdy) nxt[s] = int'(in_data);
          else if (ent[s] < 0 || lv[s]) nxt[s] = -1;
          else nxt[s] = ent[s];
          if (ent[s] >= 0 && !lv[s]) m_cnt[s]++;
        end
        if (flush_req) m_cnt[STAGES]++;
        m_acc = in_valid && rdy;
        for (int s = 0; s < STAGES; s++) ent[s] = nxt[s];
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [STAGES-1:0] lv, kl, ev, ea;
    logic              rdy;
    logic [63:0]       e;
    model_eval(lv, kl, rdy);
    for (int s = 0; s < STAGES; s++) begin
      ev[s] = ent[s] >= 0;
      ea[s] = (ent[s] < 0) || lv[s];
    end
    check("m_valid", 64'(stage_valid), 64'(ev));
    check("m_allow", 64'(stage_allow_in), 64'(ea));
    check("m_ready", 64'(in_ready), 64'(rdy));
    check("m_retire", 64'(retire), 64'(lv[STAGES-1] && !kl[STAGES-1]));
    if (lv[STAGES-1] && !kl[STAGES-1]) check("m_rdata", 64'(retire_data), 64'(ent[STAGES-1]));
    for (int s = 0; s < STAGES; s++) begin
      if (ent[s] >= 0) check($sformatf("m_data%0d", s), 64'(stage_data[s*W +: W]), 64'(ent[s]));
    end
    for (int s = 0; s <= STAGES; s++) begin
`ifdef PIPE_CTRL_PERF_EN
      e = 64'(m_cnt[s]);
`else
      e = 64'd0;
`endif
      check($sformatf("m_perf%0d", s), 64'(perf_cnt[s*32 +: 32]), e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (m_acc) in_data = in_data + 1'b1;
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = 16'd1;
    stage_over  = '0;
    flush_req   = 1'b0;
    flush_stage = '0;
    #2;
    check("rst_valid", 64'(stage_valid), 64'd0);
    check("rst_retire", 64'(retire), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_perf", 64'(perf_cnt[63:0] | perf_cnt[191:128] | perf_cnt[127:64]), 64'd0);
    flush_req = 1'b1;
    #1;
    check("rst_ready_flush", 64'(in_ready), 64'd0);
    flush_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Streaming: first retire after the 5th edge, then one per cycle in order.
    stage_over = '1;
    in_valid   = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      step();
      check($sformatf("lat_retire%0d", n), 64'(retire), 64'(n == 5));
    end
    check("lat_rdata", 64'(retire_data), 64'd1);
    for (int n = 6; n <= 8; n++) begin
      step();
      check("stream_retire", 64'(retire), 64'd1);
      check("stream_rdata", 64'(retire_data), 64'(n - 4));
    end

    // Stage 2 stalls for three cycles with the pipe full.
    stage_over = 5'b11011;
    #1;
    check("stall_ready", 64'(in_ready), 64'd0);
    step();
    check("stall_v1", 64'(stage_valid), 64'b10111);
    check("stall_rd1", 64'(retire_data), 64'd5);
    step();
    check("stall_v2", 64'(stage_valid), 64'b00111);
    check("stall_ret2", 64'(retire), 64'd0);
    step();
    check("stall_v3", 64'(stage_valid), 64'b00111);
    stage_over = '1;

    // Refill, then flush stages 0..2.
    step();
    step();
    check("refill_v", 64'(stage_valid), 64'b11111);
    check("refill_rd", 64'(retire_data), 64'd6);
    step();
    flush_req   = 1'b1;
    flush_stage = 3'd2;
    #1;
    check("fl2_ready", 64'(in_ready), 64'd0);
    check("fl2_retire", 64'(retire), 64'd1);
    check("fl2_rdata", 64'(retire_data), 64'd7);
    step();
    flush_req = 1'b0;
    #1;
    check("fl2_v", 64'(stage_valid), 64'b10000);
    check("fl2_rd_next", 64'(retire_data), 64'd8);
    step();
    check("fl2_v2", 64'(stage_valid), 64'b00001);

    // Refill, then flush everything including the retire stage.
    for (int n = 0; n < 4; n++) step();
    check("full_v", 64'(stage_valid), 64'b11111);
    flush_req   = 1'b1;
    flush_stage = 3'd7;
    #1;
    check("flall_retire", 64'(retire), 64'd0);
    step();
    flush_req = 1'b0;
    #1;
    check("flall_v", 64'(stage_valid), 64'd0);

    // Asynchronous reset mid-cycle.
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("arst_v", 64'(stage_valid), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    step();
    reset = 1'b0;
    step();
    check("post_rst_v", 64'(stage_valid), 64'b00001);
    check("post_rst_d0", 64'(stage_data[W-1:0]), 64'd19);
    for (int n = 0; n < 4; n++) step();
    check("post_rst_rd", 64'(retire_data), 64'd19);

    // Perf scenario: three-cycle stall at stage 2, then a single flush.
    stage_over = 5'b11011;
    for (int n = 0; n < 3; n++) step();
    stage_over = '1;
    step();
    step();
    flush_req   = 1'b1;
    flush_stage = 3'd1;
    step();
    flush_req = 1'b0;
    #1;
`ifdef PIPE_CTRL_PERF_EN
    check("perf_slot2", 64'(perf_cnt[2*32 +: 32]), 64'd3);
    check("perf_slot5", 64'(perf_cnt[5*32 +: 32]), 64'd1);
`else
    check("perf_off_lo", 64'(perf_cnt[95:0]), 64'd0);
    check("perf_off_hi", 64'(perf_cnt[191:96]), 64'd0);
`endif
    for (int n = 0; n < 6; n++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STAGES, default 5: number of pipeline stages, legal range 2..8; stage 0 is the youngest and stage STAGES-1 is the oldest (retire) stage.
REQ-002 Parameter W, default 64: width of the payload bus each stage carries.
REQ-003 Parameter SW, default 3: width of flush_stage; SW SHALL equal ceil(log2(STAGES)).
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  stage-0 entry offered, equivalent to a fetch-over signal.
REQ-007 in_data  in  W  payload accompanying in_valid.
REQ-008 in_ready  out  1  stage 0 accepts an entry this cycle.
REQ-009 stage_over  in  STAGES  per-stage "work complete" flag from the datapath.
REQ-010 flush_req  in  1  kill request.
REQ-011 flush_stage  in  SW  oldest stage killed by flush_req.
REQ-012 stage_valid  out  STAGES  per-stage valid bits.
REQ-013 stage_allow_in  out  STAGES  per-stage "may accept from the previous stage".
REQ-014 stage_data  out  STAGES*W  latched payload; stage i occupies bits [i*W +: W].
REQ-015 retire  out  1  single-cycle pulse when the oldest stage completes.
REQ-016 retire_data  out  W  payload of the retiring entry, valid while retire=1.
REQ-017 perf_cnt  out  (STAGES+1)*32  performance counters; see Configuration.

Function
REQ-018 allow_in[i] SHALL be ~valid[i] | (over[i] & allow_in[i+1]) for i < STAGES-1, and allow_in[STAGES-1] SHALL be ~valid[last] | over[last]; all outputs of this chain are combinational.
REQ-019 Advance into stage i (i>0) SHALL occur when valid[i-1] & over[i-1] & allow_in[i] & ~kill[i-1]; into stage 0 it SHALL occur when in_valid & in_ready.
REQ-020 On advance into a stage, that stage's valid SHALL be set and its data loaded one cycle later; data SHALL hold otherwise; each stage adds 1-cycle latency.
REQ-021 If allow_in[i]=1 and no advance into stage i occurs, valid[i] SHALL clear at the next edge (bubble).
REQ-022 in_ready SHALL be allow_in[0] & ~flush_req.
REQ-023 kill[i] SHALL be flush_req & (i <= flush_stage); killed stages SHALL clear valid at the next edge regardless of advance.
REQ-024 A stage downstream of a killed stage SHALL NOT capture the killed entry; a surviving older entry SHALL advance normally in the same cycle.
REQ-025 flush_stage >= STAGES-1 SHALL kill all stages, including the retiring one, and SHALL suppress retire in that cycle.
REQ-026 retire SHALL equal valid[last] & over[last] & ~kill[last]; retire_data SHALL be the stage_data of the last stage.
REQ-027 A full pipeline with all over=1 SHALL sustain one entry per cycle from input to retire; STAGES-cycle latency from in_valid&in_ready to retire.
REQ-028 stage_over bits of invalid stages SHALL be ignored.

Reset
REQ-029 While reset=1: all stage_valid=0, retire=0, perf_cnt=0; stage_data SHALL NOT be reset (don't-care), and in_ready SHALL be 1 unless flush_req is asserted.
REQ-030 Reset asserted mid-operation SHALL clear all valid bits immediately (asynchronously); the first accept SHALL be possible on the first edge after deassertion.

Configuration
REQ-031 Macro PIPE_CTRL_PERF_EN defined: perf_cnt slot i (i<STAGES) SHALL be a 32-bit wrapping count of cycles with valid[i] & ~(over[i] & allow_in-of-next) (stall cycles; last stage uses ~over); slot STAGES SHALL count flush_req cycles; counters reset to 0.
REQ-032 Macro PIPE_CTRL_PERF_EN undefined: perf_cnt SHALL be constant 0 and no counter flops SHALL be built.

Verification
REQ-033 STAGES=5, in_valid=1 with data 1,2,3..., all over=1 -> retire first on the 5th edge with retire_data=1, then one retire per cycle in order.
REQ-034 Hold stage_over[2]=0 for 3 cycles with the pipe full -> stages 0-2 freeze, in_ready=0, stage 3 bubbles, retire stops after the stage 3-4 entries drain.
REQ-035 Pipe full, flush_req=1 with flush_stage=2 -> next cycle valid=5'b11000 shifts to 5'b10000 with one retire; the killed entries never retire.
REQ-036 flush_req=1 with flush_stage=7 -> all valid=0 next cycle, retire=0 during the flush cycle.
REQ-037 Assert reset for 1 cycle mid-stream -> valid=0 without waiting for a clock edge; in_ready=1; data resumes correctly.
REQ-038 With PIPE_CTRL_PERF_EN, stall stage 2 for 3 cycles and flush once -> perf_cnt slot 2=3 and slot 5=1; without the macro, perf_cnt=0.
